// File: rtl/ntt_butterfly_unified_if.sv
// Valid/ready stream bundle for the unified NTT butterfly: one input beat and one result beat.
interface ntt_butterfly_unified_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1,
  parameter int TAG_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic                   scale_en;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [LANES*WIDTH-1:0] twiddle;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] a_out;
  logic [LANES*WIDTH-1:0] b_out;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, mode, scale_en, a, b, twiddle, in_tag, out_ready,
    input  in_ready, out_valid, a_out, b_out, out_tag
  );

  modport slave (
    input  in_valid, mode, scale_en, a, b, twiddle, in_tag, out_ready,
    output in_ready, out_valid, a_out, b_out, out_tag
  );
endinterface

// File: rtl/ntt_butterfly_unified.sv
// Unified CT/GS radix-2 butterfly: S0 pre-add, pipelined modular multiply, output add/sub or halving.
// Every stage shares one advance enable, so backpressure freezes the whole pipe in place.
module ntt_butterfly_unified #(
  parameter int WIDTH         = 32,
  parameter int Q             = 8380417,
  parameter int LANES         = 1,
  parameter int MULT_PIPELINE = 3,
  parameter int TAG_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ntt_butterfly_unified_if.slave bf_io
);

  localparam int                 MP = MULT_PIPELINE;
  localparam logic [WIDTH:0]     QW = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] QP = (2*WIDTH)'(Q);

  typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return (sum >= QW) ? WIDTH'(sum - QW) : WIDTH'(sum);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x >= y) ? (x - y) : WIDTH'({1'b0, x} + QW - {1'b0, y});
  endfunction

  // Halving mod Q: odd values are made even by adding the (odd) modulus first.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    return x[0] ? WIDTH'(({1'b0, x} + QW) >> 1) : (x >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    return WIDTH'(prod % QP);
  endfunction

  logic                               advance;
  lanes_t                             a_in, b_in, w_in;

  logic                               s0_valid_q, s0_mode_q, s0_scale_q;
  logic [TAG_W-1:0]                   s0_tag_q;
  lanes_t                             s0_x_q, s0_y_q, s0_w_q;
  lanes_t                             s0_x_d, s0_y_d;

  logic [MP-1:0]                      m_valid_q, m_mode_q, m_scale_q;
  logic [MP-1:0][TAG_W-1:0]           m_tag_q;
  logic [MP-1:0][LANES-1:0][WIDTH-1:0] m_x_q, m_t_q;
  lanes_t                             m_t_d;

  logic                               out_valid_q;
  logic [TAG_W-1:0]                   out_tag_q;
  lanes_t                             out_a_q, out_b_q;
  lanes_t                             out_a_d, out_b_d;

  assign advance = !out_valid_q || bf_io.out_ready;
  assign a_in    = bf_io.a;
  assign b_in    = bf_io.b;
  assign w_in    = bf_io.twiddle;

  always_comb begin
    s0_x_d = a_in;
    s0_y_d = b_in;
    if (bf_io.mode) begin
      for (int l = 0; l < LANES; l++) begin
        s0_x_d[l] = add_mod(a_in[l], b_in[l]);
        s0_y_d[l] = sub_mod(a_in[l], b_in[l]);
      end
    end
  end

  always_comb begin
    m_t_d = '0;
    for (int l = 0; l < LANES; l++) begin
      m_t_d[l] = mul_mod(s0_y_q[l], s0_w_q[l]);
    end
  end

  always_comb begin
    out_a_d = '0;
    out_b_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!m_mode_q[MP-1]) begin
        out_a_d[l] = add_mod(m_x_q[MP-1][l], m_t_q[MP-1][l]);
        out_b_d[l] = sub_mod(m_x_q[MP-1][l], m_t_q[MP-1][l]);
      end else if (m_scale_q[MP-1]) begin
        out_a_d[l] = half_mod(m_x_q[MP-1][l]);
        out_b_d[l] = half_mod(m_t_q[MP-1][l]);
      end else begin
        out_a_d[l] = m_x_q[MP-1][l];
        out_b_d[l] = m_t_q[MP-1][l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_mode_q   <= 1'b0;
      s0_scale_q  <= 1'b0;
      s0_tag_q    <= '0;
      s0_x_q      <= '0;
      s0_y_q      <= '0;
      s0_w_q      <= '0;
      m_valid_q   <= '0;
      m_mode_q    <= '0;
      m_scale_q   <= '0;
      m_tag_q     <= '0;
      m_x_q       <= '0;
      m_t_q       <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else if (advance) begin
      s0_valid_q   <= bf_io.in_valid;
      s0_mode_q    <= bf_io.mode;
      s0_scale_q   <= bf_io.scale_en;
      s0_tag_q     <= bf_io.in_tag;
      s0_x_q       <= s0_x_d;
      s0_y_q       <= s0_y_d;
      s0_w_q       <= w_in;
      m_valid_q[0] <= s0_valid_q;
      m_mode_q[0]  <= s0_mode_q;
      m_scale_q[0] <= s0_scale_q;
      m_tag_q[0]   <= s0_tag_q;
      m_x_q[0]     <= s0_x_q;
      m_t_q[0]     <= m_t_d;
      for (int k = 1; k < MP; k++) begin
        m_valid_q[k] <= m_valid_q[k-1];
        m_mode_q[k]  <= m_mode_q[k-1];
        m_scale_q[k] <= m_scale_q[k-1];
        m_tag_q[k]   <= m_tag_q[k-1];
        m_x_q[k]     <= m_x_q[k-1];
        m_t_q[k]     <= m_t_q[k-1];
      end
      out_valid_q <= m_valid_q[MP-1];
      out_tag_q   <= m_tag_q[MP-1];
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign bf_io.in_ready  = advance;
  assign bf_io.out_valid = out_valid_q;
  assign bf_io.out_tag   = out_tag_q;
  assign bf_io.a_out     = out_a_q;
  assign bf_io.b_out     = out_b_q;

endmodule

// File: tb/tb_ntt_butterfly_unified.sv
// Self-checking bench for a four-lane ntt_butterfly_unified: directed vectors, backpressured and random
// streams against a plain modular-arithmetic reference model, lane swap, and reset with work in flight.
`timescale 1ns/1ps
module tb_ntt_butterfly_unified;
  localparam int          WIDTH         = 32;
  localparam int          LANES         = 4;
  localparam int          TAG_W         = 8;
  localparam int          MULT_PIPELINE = 3;
  localparam int          LAT           = MULT_PIPELINE + 2;
  localparam int          VW            = LANES * WIDTH;
  localparam longint      QL            = 64'd8380417;
  localparam longint      INV2          = (QL + 1) / 2;
  localparam logic [31:0] Q32           = 32'd8380417;

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    logic        mode;
    logic        scale;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    logic [31:0] expA;
    logic [31:0] expB;
  } dirVec_t;

  typedef struct {
    vec_t             a;
    vec_t             b;
    logic [TAG_W-1:0] tag;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  int   passCount  = 0;
  int   checkCount = 0;

  ntt_butterfly_unified_if #(.WIDTH(WIDTH), .LANES(LANES), .TAG_W(TAG_W)) bf ();

  ntt_butterfly_unified #(
    .WIDTH(WIDTH), .Q(8380417), .LANES(LANES), .MULT_PIPELINE(MULT_PIPELINE), .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bf_io(bf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input vec_t actual, input vec_t expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  // Reference: textbook CT/GS butterfly with halving done as multiplication by 2^-1 mod Q.
  function automatic result_t refModel(input logic mode, input logic scale, input vec_t av,
                                       input vec_t bv, input vec_t wv, input logic [TAG_W-1:0] tag);
    result_t r;
    longint  a, b, w, x, y;
    r.tag = tag;
    r.a   = '0;
    r.b   = '0;
    for (int l = 0; l < LANES; l++) begin
      a = {32'd0, av[l*WIDTH +: WIDTH]};
      b = {32'd0, bv[l*WIDTH +: WIDTH]};
      w = {32'd0, wv[l*WIDTH +: WIDTH]};
      if (!mode) begin
        x = (a + (b * w) % QL) % QL;
        y = (a - (b * w) % QL + QL) % QL;
      end else begin
        x = (a + b) % QL;
        y = (((a - b + QL) % QL) * w) % QL;
        if (scale) begin
          x = (x * INV2) % QL;
          y = (y * INV2) % QL;
        end
      end
      r.a[l*WIDTH +: WIDTH] = x[31:0];
      r.b[l*WIDTH +: WIDTH] = y[31:0];
    end
    return r;
  endfunction

  function automatic vec_t randVec();
    vec_t v;
    for (int l = 0; l < LANES; l++) begin
      v[l*WIDTH +: WIDTH] = (($urandom & 7) == 0) ? Q32 - 32'd1 : $urandom % Q32;
    end
    return v;
  endfunction

  function automatic vec_t revLanes(input vec_t v);
    vec_t r;
    for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = v[(LANES-1-l)*WIDTH +: WIDTH];
    return r;
  endfunction

  // One isolated transaction; reports the result and the cycles until out_valid.
  task automatic applyStimulus(input logic mode, input logic scale, input vec_t av, input vec_t bv,
                               input vec_t wv, input logic [TAG_W-1:0] tag,
                               output result_t got, output int lat);
    @(negedge clk);
    bf.in_valid  = 1'b1;
    bf.mode      = mode;
    bf.scale_en  = scale;
    bf.a         = av;
    bf.b         = bv;
    bf.twiddle   = wv;
    bf.in_tag    = tag;
    bf.out_ready = 1'b1;
    @(negedge clk);
    bf.in_valid = 1'b0;
    lat = 1;
    while (!bf.out_valid && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
    got.a   = bf.a_out;
    got.b   = bf.b_out;
    got.tag = bf.out_tag;
  endtask

  // Streams n transactions; pattern 0 = out_ready 1,0,0 repeating, 1 = random, 2 = blocked then open.
  task automatic runStream(input string name, input int n, input int pattern, input bit altMode,
                           input logic [TAG_W-1:0] tagBase);
    result_t          expQ[$];
    result_t          e;
    int               sent = 0, got = 0, cyc = 0, irViol = 0, stabViol = 0;
    bit               needNew = 1'b1, holdValid = 1'b0;
    vec_t             holdA = '0, holdB = '0;
    logic [TAG_W-1:0] holdT = '0;
    while (got < n && cyc < 50 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (holdValid && (!bf.out_valid || bf.a_out !== holdA || bf.b_out !== holdB || bf.out_tag !== holdT))
        stabViol++;
      if (sent < n) begin
        if (needNew) begin
          bf.mode     = altMode ? sent[0] : (($urandom & 1) == 1);
          bf.scale_en = ($urandom & 1) == 1;
          bf.a        = randVec();
          bf.b        = randVec();
          bf.twiddle  = randVec();
          bf.in_tag   = tagBase + TAG_W'(sent);
          needNew     = 1'b0;
        end
        bf.in_valid = 1'b1;
      end else begin
        bf.in_valid = 1'b0;
      end
      case (pattern)
        0:       bf.out_ready = ((cyc - 1) % 3) == 0;
        1:       bf.out_ready = ($urandom & 1) == 1;
        default: bf.out_ready = cyc > 15;
      endcase
      #1;
      if (bf.in_ready !== (!bf.out_valid || bf.out_ready)) irViol++;
      if (bf.out_valid && bf.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({name, "_unexpected_output"}, VW'(1), VW'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("%s_tag%0d", name, got), VW'(bf.out_tag), VW'(e.tag));
          checkOutput($sformatf("%s_a%0d", name, got), bf.a_out, e.a);
          checkOutput($sformatf("%s_b%0d", name, got), bf.b_out, e.b);
        end
        got++;
      end
      holdValid = bf.out_valid && !bf.out_ready;
      holdA     = bf.a_out;
      holdB     = bf.b_out;
      holdT     = bf.out_tag;
      if (bf.in_valid && bf.in_ready) begin
        expQ.push_back(refModel(bf.mode, bf.scale_en, bf.a, bf.b, bf.twiddle, bf.in_tag));
        sent++;
        needNew = 1'b1;
      end
    end
    bf.in_valid = 1'b0;
    checkOutput({name, "_count"}, VW'(got), VW'(n));
    checkOutput({name, "_in_ready_rule_violations"}, VW'(irViol), VW'(0));
    checkOutput({name, "_stall_stability_violations"}, VW'(stabViol), VW'(0));
  endtask

  initial begin
    dirVec_t dv[9];
    result_t got, got2, e;
    int      lat, seen;
    vec_t    av, bv, wv;

    dv[0] = '{1'b0, 1'b0, 32'd5,       32'd3,       32'd2,       32'd11,      32'd8380416};
    dv[1] = '{1'b1, 1'b0, 32'd5,       32'd3,       32'd2,       32'd8,       32'd4};
    dv[2] = '{1'b1, 1'b1, 32'd5,       32'd3,       32'd2,       32'd4,       32'd2};
    dv[3] = '{1'b1, 1'b1, 32'd4,       32'd3,       32'd1,       32'd4190212, 32'd4190209};
    dv[4] = '{1'b0, 1'b0, 32'd8380416, 32'd1,       32'd1,       32'd0,       32'd8380415};
    dv[5] = '{1'b1, 1'b0, 32'd0,       32'd1,       32'd1,       32'd1,       32'd8380416};
    dv[6] = '{1'b0, 1'b1, 32'd5,       32'd3,       32'd2,       32'd11,      32'd8380416};
    dv[7] = '{1'b0, 1'b0, 32'd0,       32'd8380416, 32'd8380416, 32'd1,       32'd8380416};
    dv[8] = '{1'b1, 1'b1, 32'd0,       32'd0,       32'd7,       32'd0,       32'd0};

    rst          = 1'b0;
    bf.in_valid  = 1'b0;
    bf.mode      = 1'b0;
    bf.scale_en  = 1'b0;
    bf.a         = '0;
    bf.b         = '0;
    bf.twiddle   = '0;
    bf.in_tag    = '0;
    bf.out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", VW'(bf.in_ready), VW'(1));
    checkOutput("reset_out_valid", VW'(bf.out_valid), VW'(0));
    checkOutput("reset_a_out", bf.a_out, '0);
    checkOutput("reset_b_out", bf.b_out, '0);
    checkOutput("reset_out_tag", VW'(bf.out_tag), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", VW'(bf.in_ready), VW'(1));

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(dv[i].mode, dv[i].scale, {LANES{dv[i].a}}, {LANES{dv[i].b}}, {LANES{dv[i].w}},
                    TAG_W'(8'h11 + i), got, lat);
      checkOutput($sformatf("dir%0d_latency", i), VW'(lat), VW'(LAT));
      checkOutput($sformatf("dir%0d_a_out", i), got.a, {LANES{dv[i].expA}});
      checkOutput($sformatf("dir%0d_b_out", i), got.b, {LANES{dv[i].expB}});
      checkOutput($sformatf("dir%0d_tag", i), VW'(got.tag), VW'(8'h11 + i));
    end

    $display("[TB] distinct lanes and lane swap");
    av = {32'd8380416, 32'd77, 32'd1234567, 32'd4};
    bv = {32'd3, 32'd8000000, 32'd1234567, 32'd9};
    wv = {32'd2, 32'd65536, 32'd8380416, 32'd1};
    applyStimulus(1'b1, 1'b1, av, bv, wv, 8'h40, got, lat);
    e = refModel(1'b1, 1'b1, av, bv, wv, 8'h40);
    checkOutput("lanes_a_out", got.a, e.a);
    checkOutput("lanes_b_out", got.b, e.b);
    applyStimulus(1'b1, 1'b1, revLanes(av), revLanes(bv), revLanes(wv), 8'h41, got2, lat);
    checkOutput("lanes_swapped_a_out", got2.a, revLanes(got.a));
    checkOutput("lanes_swapped_b_out", got2.b, revLanes(got.b));
    checkOutput("lanes_swapped_tag", VW'(got2.tag), VW'(8'h41));

    $display("[TB] streams");
    runStream("backpressure", 10, 0, 1'b1, 8'h60);
    runStream("fill_blocked", 12, 2, 1'b0, 8'h80);
    runStream("random", 60, 1, 1'b0, 8'hA0);

    $display("[TB] reset with transactions in flight");
    @(negedge clk);
    bf.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bf.in_valid = 1'b1;
      bf.mode     = 1'b0;
      bf.scale_en = 1'b0;
      bf.a        = randVec();
      bf.b        = randVec();
      bf.twiddle  = randVec();
      bf.in_tag   = TAG_W'(8'hE0 + i);
      @(negedge clk);
    end
    bf.in_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    checkOutput("flight_out_valid_before_reset", VW'(bf.out_valid), VW'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("flight_reset_out_valid", VW'(bf.out_valid), VW'(0));
    checkOutput("flight_reset_a_out", bf.a_out, '0);
    checkOutput("flight_reset_out_tag", VW'(bf.out_tag), VW'(0));
    checkOutput("flight_reset_in_ready", VW'(bf.in_ready), VW'(1));
    @(negedge clk);
    rst          = 1'b0;
    bf.out_ready = 1'b1;
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bf.out_valid) seen++;
    end
    checkOutput("flight_no_replay", VW'(seen), VW'(0));
    applyStimulus(1'b0, 1'b0, {LANES{32'd5}}, {LANES{32'd3}}, {LANES{32'd2}}, 8'h11, got, lat);
    checkOutput("flight_new_latency", VW'(lat), VW'(LAT));
    checkOutput("flight_new_a_out", got.a, {LANES{32'd11}});
    checkOutput("flight_new_b_out", got.b, {LANES{32'd8380416}});
    checkOutput("flight_new_tag", VW'(got.tag), VW'(8'h11));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
